// File: rtl/parallel_to_serial_tx.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock, reloading on the last bit for gapless streams.
module parallel_to_serial_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       word_count
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             accept;

  // Move the next bit into the output position, zero-filling the far end.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
    if (MSB_FIRST)
      return {s[WIDTH-2:0], 1'b0};
    else
      return {1'b0, s[WIDTH-1:1]};
  endfunction

  assign last_bit    = (state == SHIFT) && (bit_cnt == '0);
  assign in_ready    = rst_n && ((state == IDLE) || last_bit);
  assign accept      = in_valid && in_ready;
  assign ser_valid   = (state == SHIFT);
  assign busy        = ser_valid;
  assign ser_out     = ser_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign frame_start = ser_valid && (bit_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= data_in;
            bit_cnt <= LAST_IDX;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            shreg   <= shift_out(shreg);
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            // Last bit: the word completes here; a same-edge accept keeps the stream gapless.
            word_count <= word_count + 8'd1;
            if (accept) begin
              shreg   <= data_in;
              bit_cnt <= LAST_IDX;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Bench for parallel_to_serial_tx: MSB-first and LSB-first instances share inputs
// and are checked every cycle against a bit-queue reference model.
module tb_parallel_to_serial_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         in_valid;

  logic         rdy_m, so_m, sv_m, fs_m, bz_m;
  logic [7:0]   wc_m;
  logic         rdy_l, so_l, sv_l, fs_l, bz_l;
  logic [7:0]   wc_l;

  always #5 clk = ~clk;

  parallel_to_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m), .frame_start(fs_m),
    .busy(bz_m), .word_count(wc_m)
  );

  parallel_to_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l), .frame_start(fs_l),
    .busy(bz_l), .word_count(wc_l)
  );

  // Reference model: every bit still to be sent, in wire order.
  typedef struct packed {
    bit bm;     // bit as seen on the MSB-first line
    bit bl;     // bit as seen on the LSB-first line
    bit first;
    bit last;
  } ent_t;

  ent_t q[$];
  int   wc;
  int   n_checks;
  int   n_pass;
  bit   cnt_en;
  int   vcount;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: apply inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, output bit acc);
    logic e_sv, e_fs, e_om, e_ol, e_rdy;
    #1;
    in_valid = v;
    data_in  = d;
    rst_n    = r;
    @(negedge clk);
    e_sv  = (q.size() > 0);
    e_fs  = e_sv ? q[0].first : 1'b0;
    e_om  = e_sv ? q[0].bm : 1'b0;
    e_ol  = e_sv ? q[0].bl : 1'b0;
    e_rdy = r && (q.size() <= 1);
    chk("ser_valid_m", 32'(sv_m), 32'(e_sv));
    chk("busy_m", 32'(bz_m), 32'(e_sv));
    chk("ser_out_m", 32'(so_m), 32'(e_om));
    chk("frame_start_m", 32'(fs_m), 32'(e_fs));
    chk("in_ready_m", 32'(rdy_m), 32'(e_rdy));
    chk("word_count_m", 32'(wc_m), 32'(wc));
    chk("ser_valid_l", 32'(sv_l), 32'(e_sv));
    chk("ser_out_l", 32'(so_l), 32'(e_ol));
    chk("frame_start_l", 32'(fs_l), 32'(e_fs));
    chk("in_ready_l", 32'(rdy_l), 32'(e_rdy));
    chk("word_count_l", 32'(wc_l), 32'(wc));
    if (cnt_en && sv_m === 1'b1) vcount++;
    acc = r && v && e_rdy;
    @(posedge clk);
    if (!r) begin
      q.delete();
      wc = 0;
    end else begin
      if (q.size() > 0) begin
        if (q[0].last) wc = (wc + 1) % 256;
        void'(q.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          ent_t e;
          e.bm    = d[W-1-i];
          e.bl    = d[i];
          e.first = (i == 0);
          e.last  = (i == W - 1);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b1, a);
  endtask

  // Hold in_valid with a word until the block takes it, within a cycle budget.
  task automatic send(input logic [W-1:0] w);
    bit a;
    int t;
    a = 1'b0;
    t = 0;
    while (!a && t < 2 * W + 2) begin
      cycle(1'b1, w, 1'b1, a);
      t++;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit a;
    n_checks = 0;
    n_pass   = 0;
    wc       = 0;
    cnt_en   = 1'b0;
    vcount   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    @(posedge clk);

    // Reset then idle
    cycle(1'b0, '0, 1'b0, a);
    cycle(1'b0, '0, 1'b0, a);
    idle(5);
    chk("idle_word_count", 32'(wc_m), 32'd0);

    // Single word 1011, one-cycle pulse
    cycle(1'b1, 4'b1011, 1'b1, a);
    idle(6);
    chk("single_word_count", 32'(wc_m), 32'd1);

    // Back-to-back A then 5
    send(4'hA);
    send(4'h5);
    idle(6);
    chk("b2b_word_count", 32'(wc_m), 32'd3);

    // Reset during bit 2 of F, then a clean word 3
    send(4'hF);
    idle(1);
    cycle(1'b0, '0, 1'b0, a);
    idle(1);
    chk("mid_reset_count", 32'(wc_m), 32'd0);
    send(4'h3);
    idle(5);

    // LSB-first line shows 1,0,0,0 for word 0001
    send(4'b0001);
    idle(5);
    chk("lsb_word_count", 32'(wc_l), 32'd2);

    // Random valid toggling and data churn while not ready
    for (int i = 0; i < 80; i++) cycle(1'($urandom), W'($urandom), 1'b1, a);
    idle(6);

    // 257 back-to-back words from a clean count
    cycle(1'b0, '0, 1'b0, a);
    cnt_en = 1'b1;
    for (int i = 0; i < 257; i++) send(W'($urandom));
    idle(6);
    cnt_en = 1'b0;
    chk("wrap_valid_cycles", 32'(vcount), 32'(257 * W));
    chk("wrap_word_count", 32'(wc_m), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
